digest_reader: RTL

- Downstream of the block controller: consumes the hash engine's digest after a final-block request and returns it to the processor over the BUS_WIDTH data bus.
- Arms on the controller's `final` pulse and captures the digest on the engine's digest_valid rising edge.
- Streams the captured digest out MS word first, with a valid/ready handshake and a last-word marker.
- Flags a sticky overrun when a new final request arrives before the previous digest has been fully read.

---
 rtl/digest_reader.sv | 101 ++++++++++
 1 files changed

// File: rtl/digest_reader.sv
// Captures the hash engine digest after a final request and streams it out
// MS word first over a valid/ready bus, flagging overlapping requests as overrun.
module digest_reader #(
  parameter int BUS_WIDTH    = 32,
  parameter int DIGEST_WIDTH = 512,
  parameter int OUT_BYTES    = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    final_in,
  input  logic                    digest_valid,
  input  logic [DIGEST_WIDTH-1:0] digest_in,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int OUT_W  = OUT_BYTES * 8;
  localparam int NWORDS = OUT_W / BUS_WIDTH;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_t;

  state_t             state;
  logic               dv_q;
  logic [OUT_W-1:0]   digest_reg;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               dv_rise;
  logic               last_xfer;
  logic               ovr_set;

  function automatic logic [BUS_WIDTH-1:0] word_at(input logic [OUT_W-1:0] d,
                                                   input logic [CNT_W-1:0] idx);
    logic [OUT_W-1:0] sh;
    sh = d << (int'(idx) * BUS_WIDTH);
    return sh[OUT_W-1 -: BUS_WIDTH];
  endfunction

  assign cnt_next  = cnt + 1'b1;
  assign dv_rise   = digest_valid & ~dv_q;
  assign last_xfer = (state == STREAM) & dout_valid & dout_ready & dout_last;
  // A request while one is pending is dropped, except exactly on the last-word handoff.
  assign ovr_set   = final_in & ((state == ARMED) | ((state == STREAM) & ~last_xfer));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dv_q       <= 1'b0;
      digest_reg <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dv_q    <= digest_valid;
      overrun <= ovr_set | (overrun & ~overrun_clr);
      case (state)
        IDLE: begin
          if (final_in) state <= ARMED;
        end
        ARMED: begin
          if (dv_rise) begin
            digest_reg <= digest_in[DIGEST_WIDTH-1 -: OUT_W];
            cnt        <= '0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          // First STREAM cycle presents word 0 from the freshly captured register.
          if (!dout_valid) begin
            dout       <= word_at(digest_reg, cnt);
            dout_valid <= 1'b1;
            dout_last  <= (cnt == LAST_IDX);
          end else if (dout_ready) begin
            if (dout_last) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              cnt        <= '0;
              state      <= final_in ? ARMED : IDLE;
            end else begin
              cnt        <= cnt_next;
              dout       <= word_at(digest_reg, cnt_next);
              dout_last  <= (cnt_next == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
